// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address, ACKs by pulling SDA and strobes out each received data byte.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [7:0] byte_count,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    state_t                 state;
    logic [BIT_W-1:0]       bit_cnt;
    logic [7:0]             shift;
    logic                   addr_ok;
    logic                   ack_phase;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;

    logic       scl_now_c, sda_now_c;
    logic       scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0] byte_next_c;

    // Line events come from the last sync stage compared with the history flop
    always_comb begin
        scl_now_c   = scl_sync[SYNC_STAGES-1];
        sda_now_c   = sda_sync[SYNC_STAGES-1];
        scl_rise_c  = scl_now_c & ~scl_hist;
        scl_fall_c  = ~scl_now_c & scl_hist;
        start_c     = scl_now_c & scl_hist & sda_hist & ~sda_now_c;
        stop_c      = scl_now_c & scl_hist & ~sda_hist & sda_now_c;
        byte_next_c = {shift[6:0], sda_now_c};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_now_c;
            sda_hist <= sda_now_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            addr_ok    <= 1'b0;
            ack_phase  <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            byte_count <= '0;
            busy       <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            // Bus conditions override any SCL edge seen in the same cycle
            if (start_c) begin
                start_det  <= 1'b1;
                state      <= ADDR;
                busy       <= 1'b1;
                bit_cnt    <= '0;
                byte_count <= '0;
                sda_oe     <= 1'b0;
            end else if (stop_c) begin
                stop_det <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, WAIT_STOP: begin
                    end
                    ADDR: begin
                        if (scl_rise_c) begin
                            shift <= byte_next_c;
                            if (bit_cnt == BIT_W'(7)) begin
                                bit_cnt   <= '0;
                                state     <= ADDR_ACK;
                                ack_phase <= 1'b0;
                                addr_ok   <= (byte_next_c[7:1] == SLAVE_ADDR) && !byte_next_c[0];
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_c) begin
                            if (!ack_phase) begin
                                sda_oe    <= addr_ok;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= addr_ok ? DATA : WAIT_STOP;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise_c) begin
                            shift <= byte_next_c;
                            if (bit_cnt == BIT_W'(7)) begin
                                bit_cnt   <= '0;
                                state     <= DATA_ACK;
                                ack_phase <= 1'b0;
                                rx_data   <= byte_next_c;
                                rx_valid  <= 1'b1;
                                if (byte_count != 8'hFF)
                                    byte_count <= byte_count + 8'd1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    DATA_ACK: begin
                        if (scl_fall_c) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged open-drain master plus event monitors.
module tb_i2c_slave_rx;

    localparam int unsigned Q = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] byte_count;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_start = 0;
    int n_stop  = 0;
    logic [7:0] last_rx = 8'h00;
    logic       prev_valid = 1'b0;
    logic       valid_long = 1'b0;
    logic       oe_seen = 1'b0;
    logic       ack;
    int v0, s0, p0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .byte_count (byte_count),
        .busy       (busy),
        .start_det  (start_det),
        .stop_det   (stop_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid <= n_valid + 1;
            last_rx <= rx_data;
        end
        if (rx_valid && prev_valid) valid_long <= 1'b1;
        prev_valid <= rx_valid;
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
        if (sda_oe)    oe_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; waitq();
        scl_m = 1'b0; waitq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; waitq();
        scl_m = 1'b1; waitq();
        sda_m = 1'b0; waitq();
        scl_m = 1'b0; waitq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; waitq();
        scl_m = 1'b1; waitq();
        sda_m = 1'b1; waitq(); waitq();
    endtask

    task automatic send_bit(input logic b, output logic line);
        sda_m = b;    waitq();
        scl_m = 1'b1; waitq();
        line = sda_line; waitq();
        scl_m = 1'b0; waitq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic dummy;
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], dummy);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic line;
        send_bits(b, 8);
        send_bit(1'b1, line);
        acked = ~line;
    endtask

    initial begin
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(posedge clk);
        settle();
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_outputs", {19'd0, rx_data, rx_valid, busy, start_det, stop_det, byte_count[0]},
              32'd0);
        check("reset_byte_count", 32'(byte_count), 32'd0);
        @(posedge clk); reset = 1'b0;
        repeat (4) @(posedge clk);

        // Write 0x50+W, 0xA5, STOP
        s0 = n_start; v0 = n_valid; p0 = n_stop;
        i2c_start(); settle();
        check("t2_start_det", 32'(n_start - s0), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        send_byte(8'hA0, ack);
        check("t2_addr_ack", 32'(ack), 32'd1);
        send_byte(8'hA5, ack);
        check("t2_data_ack", 32'(ack), 32'd1);
        settle();
        check("t2_valid_count", 32'(n_valid - v0), 32'd1);
        check("t2_rx_data", 32'(last_rx), 32'hA5);
        check("t2_byte_count", 32'(byte_count), 32'd1);
        i2c_stop(); settle();
        check("t2_stop_det", 32'(n_stop - p0), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_oe_after", 32'(sda_oe), 32'd0);

        // Reset during the data ACK releases SDA on the same edge
        i2c_start();
        send_byte(8'hA0, ack);
        send_bits(8'h12, 8);
        settle();
        check("t1_oe_in_ack", 32'(sda_oe), 32'd1);
        @(posedge clk); reset = 1'b1;
        @(posedge clk); settle();
        check("t1_oe_reset", 32'(sda_oe), 32'd0);
        check("t1_busy_reset", 32'(busy), 32'd0);
        reset = 1'b0;
        sda_m = 1'b1; waitq();
        scl_m = 1'b1; waitq();

        // Address mismatch 0x51+W
        v0 = n_valid;
        i2c_start();
        oe_seen = 1'b0;
        send_byte(8'hA2, ack);
        check("t3_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h3C, ack);
        check("t3_data_nack", 32'(ack), 32'd0);
        settle();
        check("t3_oe_never", 32'(oe_seen), 32'd0);
        check("t3_no_valid", 32'(n_valid - v0), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        i2c_stop(); settle();
        check("t3_busy_after", 32'(busy), 32'd0);

        // Read request 0x50+R
        i2c_start();
        oe_seen = 1'b0;
        send_byte(8'hA1, ack);
        check("t4_read_nack", 32'(ack), 32'd0);
        send_byte(8'h77, ack);
        settle();
        check("t4_oe_never", 32'(oe_seen), 32'd0);
        check("t4_wait_stop_busy", 32'(busy), 32'd1);
        check("t4_no_valid", 32'(n_valid - v0), 32'd0);
        i2c_stop();

        // Three bytes, repeated START, 0x50+W, 0xFF
        v0 = n_valid; s0 = n_start;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        send_byte(8'h02, ack);
        send_byte(8'h03, ack);
        settle();
        check("t5_three_valid", 32'(n_valid - v0), 32'd3);
        check("t5_byte_count3", 32'(byte_count), 32'd3);
        check("t5_rx_03", 32'(last_rx), 32'h03);
        i2c_rstart(); settle();
        check("t5_rstart_det", 32'(n_start - s0), 32'd2);
        check("t5_count_cleared", 32'(byte_count), 32'd0);
        send_byte(8'hA0, ack);
        check("t5_readdr_ack", 32'(ack), 32'd1);
        send_byte(8'hFF, ack);
        settle();
        check("t5_byte_count1", 32'(byte_count), 32'd1);
        check("t5_rx_ff", 32'(last_rx), 32'hFF);
        i2c_stop();

        // STOP after 4 data bits
        v0 = n_valid; p0 = n_stop;
        i2c_start();
        send_byte(8'hA0, ack);
        send_bits(8'hA0, 4);
        i2c_stop(); settle();
        check("t6_no_valid", 32'(n_valid - v0), 32'd0);
        check("t6_byte_count", 32'(byte_count), 32'd0);
        check("t6_stop_det", 32'(n_stop - p0), 32'd1);
        check("t6_oe", 32'(sda_oe), 32'd0);
        check("t6_rx_held", 32'(rx_data), 32'hFF);
        check("valid_one_cycle", 32'(valid_long), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
